step_ramp_generator: RTL and testbench

- Trapezoidal-profile step/direction generator for the A4988 driving the NEMA 17 bipolar motor.
- Replaces the fixed-rate STEP divider feeding the driver: accepts a move command (step count, direction) via start/busy/done handshake.
- Emits STEP pulses that accelerate from START_PERIOD to MIN_PERIOD, cruise, then decelerate symmetrically; drives DIR with setup time before the first pulse.
- MS1..MS3 remain driven by the existing microstepping control.

---
 rtl/step_ramp_generator_pkg.sv | 18 +
 rtl/step_pulse_timer.sv | 41 ++++
 rtl/step_ramp_generator.sv | 157 +++++++++++++++
 tb/tb_step_ramp_generator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ramp_generator_pkg.sv
// Shared state encoding and default timing constants for the trapezoidal STEP/DIR generator.
package step_ramp_generator_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned START_PERIOD     = 500_000;
  localparam int unsigned MIN_PERIOD       = 50_000;
  localparam int unsigned PERIOD_STEP      = 5_000;
  localparam int unsigned PULSE_CYCLES     = 100;
  localparam int unsigned DIR_SETUP_CYCLES = 50;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/step_pulse_timer.sv
// Generates one STEP window per enable run: high for PULSE_CYCLES, low for the rest of i_period.
// The first window starts on the cycle after i_en rises; dropping i_en clears the timer at once.
module step_pulse_timer #(
  parameter int unsigned PER_W        = 20,
  parameter int unsigned PULSE_CYCLES = 100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [PER_W-1:0] i_period,
  output logic             o_step_out,
  output logic             o_pulse_end_c,
  output logic             o_end_of_window_c
);

  logic [PER_W-1:0] r_pos;
  logic             r_active;
  logic             r_step;
  logic [PER_W-1:0] w_pos_nxt;

  assign w_pos_nxt         = r_pos + PER_W'(1);
  assign o_end_of_window_c = r_active && (r_pos == (i_period - PER_W'(1)));
  assign o_pulse_end_c     = r_active && (r_pos == PER_W'(PULSE_CYCLES - 1));
  assign o_step_out        = r_step;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_active <= 1'b0;
      r_pos    <= '0;
      r_step   <= 1'b0;
    end else if (!r_active || o_end_of_window_c) begin
      r_active <= 1'b1;
      r_pos    <= '0;
      r_step   <= 1'b1;
    end else begin
      r_pos  <= w_pos_nxt;
      r_step <= (w_pos_nxt < PER_W'(PULSE_CYCLES));
    end
  end

endmodule

// File: rtl/step_ramp_generator.sv
// Move sequencer for the A4988: DIR setup, then a symmetric accelerate/cruise/decelerate STEP train.
// Accepts one move per start/busy/done handshake; abort finishes any STEP pulse already high.
module step_ramp_generator
  import step_ramp_generator_pkg::*;
#(
  parameter int unsigned START_PERIOD     = step_ramp_generator_pkg::START_PERIOD,
  parameter int unsigned MIN_PERIOD       = step_ramp_generator_pkg::MIN_PERIOD,
  parameter int unsigned PERIOD_STEP      = step_ramp_generator_pkg::PERIOD_STEP,
  parameter int unsigned PULSE_CYCLES     = step_ramp_generator_pkg::PULSE_CYCLES,
  parameter int unsigned DIR_SETUP_CYCLES = step_ramp_generator_pkg::DIR_SETUP_CYCLES,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_target_steps,
  input  logic             i_dir_in,
  output logic             o_step_out,
  output logic             o_dir_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_step_count
);

  localparam int unsigned PER_W = $clog2(START_PERIOD + 1);
  localparam int unsigned SET_W = (DIR_SETUP_CYCLES > 1) ? $clog2(DIR_SETUP_CYCLES) : 1;
  localparam logic [PER_W-1:0] P_START = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] P_MIN   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] P_STEP  = PER_W'(PERIOD_STEP);

  state_t           r_state;
  logic [SET_W-1:0] r_setup_cnt;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_accel;
  logic [PER_W-1:0] r_cur_period;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  logic             w_step;
  logic             w_pulse_end;
  logic             w_eow;
  logic             w_tmr_en;
  logic [CNT_W-1:0] w_next_count;
  logic [CNT_W-1:0] w_remaining;
  logic             w_last;
  logic             w_abort_exit;
  logic             w_setup_last;

  assign w_next_count = r_count + CNT_W'(1);
  assign w_remaining  = r_target - w_next_count;
  assign w_last       = (w_next_count == r_target);
  assign w_abort_exit = i_abort && (!w_step || w_pulse_end);
  assign w_setup_last = (r_setup_cnt == SET_W'(DIR_SETUP_CYCLES - 1));

  // Timer runs only while the next state is RUN, so no stray pulse starts on exit.
  always_comb begin
    w_tmr_en = 1'b0;
    case (r_state)
      S_SETUP: w_tmr_en = !i_abort && w_setup_last;
      S_RUN:   w_tmr_en = !w_abort_exit && !(w_eow && w_last);
      default: w_tmr_en = 1'b0;
    endcase
  end

  step_pulse_timer #(
    .PER_W       (PER_W),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_en             (w_tmr_en),
    .i_period         (r_cur_period),
    .o_step_out       (w_step),
    .o_pulse_end_c    (w_pulse_end),
    .o_end_of_window_c(w_eow)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_setup_cnt  <= '0;
      r_target     <= '0;
      r_count      <= '0;
      r_accel      <= '0;
      r_cur_period <= P_START;
      r_dir        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_target     <= i_target_steps;
            r_dir        <= i_dir_in;
            r_count      <= '0;
            r_accel      <= '0;
            r_cur_period <= P_START;
            r_setup_cnt  <= '0;
            if (i_target_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (i_abort) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_setup_last) begin
            r_state <= S_RUN;
          end else begin
            r_setup_cnt <= r_setup_cnt + SET_W'(1);
          end
        end
        S_RUN: begin
          if (w_abort_exit) begin
            if (w_step) r_count <= w_next_count;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_eow) begin
            r_count <= w_next_count;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_remaining <= r_accel) begin
              // Decelerate mirrors the steps spent accelerating; saturate before adding.
              r_cur_period <= ((P_START - r_cur_period) <= P_STEP) ? P_START : (r_cur_period + P_STEP);
              r_accel      <= r_accel - CNT_W'(1);
            end else if (r_cur_period > P_MIN) begin
              r_cur_period <= ((r_cur_period - P_MIN) <= P_STEP) ? P_MIN : (r_cur_period - P_STEP);
              r_accel      <= r_accel + CNT_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_step_out   = w_step;
  assign o_dir_out    = r_dir;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_step_count = r_count;

endmodule

// File: tb/tb_step_ramp_generator.sv
// Self-checking bench: move records queued at start, checked against observed STEP timing at done.
module tb_step_ramp_generator;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SP    = 100;
  localparam int unsigned MP    = 40;
  localparam int unsigned PS    = 20;
  localparam int unsigned PC    = 10;
  localparam int unsigned DS    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] target;
  logic             dir_in;
  logic             o_step_out;
  logic             o_dir_out;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_step_count;

  always #5 clk = ~clk;

  step_ramp_generator #(
    .START_PERIOD    (SP),
    .MIN_PERIOD      (MP),
    .PERIOD_STEP     (PS),
    .PULSE_CYCLES    (PC),
    .DIR_SETUP_CYCLES(DS),
    .CNT_W           (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_target_steps(target),
    .i_dir_in      (dir_in),
    .o_step_out    (o_step_out),
    .o_dir_out     (o_dir_out),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_step_count  (o_step_count)
  );

  typedef struct {
    int target;
    int dir;
    int count;
    int done_off;
    int npulse;
    bit aborted;
    int per[10];
    int n;
  } vec_t;

  vec_t tbl[6];
  vec_t sb_q[$];
  vec_t m_e;
  int   rises[$];
  int   falls[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   busy_err = 0;
  bit   prev_step = 1'b0;
  bit   prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each edge; label = edge index + 1.
  initial begin
    int lbl, per_err, wid_err, np;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      lbl = cyc + 1;
      if (prev_done) chk("done_one_cycle", int'(o_done), 0);
      prev_done = o_done;
      if (o_step_out && !prev_step) rises.push_back(lbl);
      if (!o_step_out && prev_step) falls.push_back(lbl);
      prev_step = o_step_out;
      if (o_done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no move pending (cycle %0d)", cyc);
        end else begin
          m_e = sb_q.pop_front();
          np  = rises.size();
          chk("done_off",     lbl - m_e.n, m_e.done_off);
          chk("step_count",   int'(o_step_count), m_e.count);
          chk("dir_out",      int'(o_dir_out), m_e.dir);
          chk("busy_at_done", int'(o_busy), 0);
          chk("busy_gaps",    busy_err, 0);
          chk("pulses",       np, m_e.npulse);
          if (np > 0) chk("first_rise", rises[0] - m_e.n, 1 + DS);
          wid_err = (falls.size() != np) ? 1 : 0;
          for (int i = 0; i < falls.size() && i < np; i++)
            if (falls[i] - rises[i] != PC) wid_err++;
          if (np > 0) chk("pulse_width", wid_err, 0);
          per_err = 0;
          for (int i = 1; i < np && i <= 10; i++)
            if (rises[i] - rises[i-1] != m_e.per[i-1]) per_err++;
          if (!m_e.aborted && np > 0 && np <= 10)
            if (lbl - rises[np-1] != m_e.per[np-1]) per_err++;
          if (np > 1) chk("periods", per_err, 0);
        end
        rises.delete();
        falls.delete();
        busy_err = 0;
      end else if (sb_q.size() > 0 && lbl > sb_q[0].n && !o_busy) begin
        busy_err++;
      end
    end
  end

  task automatic launch(input int idx, output int n);
    vec_t e;
    @(negedge clk);
    target = CNT_W'(tbl[idx].target);
    dir_in = tbl[idx].dir[0];
    start  = 1'b1;
    e   = tbl[idx];
    e.n = cyc + 1;
    n   = e.n;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_label(input int lbl);
    while (cyc + 1 < lbl) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no done within %0d cycles expected done", budget);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_step"},  int'(o_step_out), 0);
    chk({tag, "_dir"},   int'(o_dir_out), 0);
    chk({tag, "_busy"},  int'(o_busy), 0);
    chk({tag, "_done"},  int'(o_done), 0);
    chk({tag, "_count"}, int'(o_step_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    tbl[0] = '{target: 10, dir: 1, count: 10, done_off: 646, npulse: 10, aborted: 1'b0,
               per: '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100}, n: 0};
    tbl[1] = '{target: 3,  dir: 0, count: 3,  done_off: 286, npulse: 3,  aborted: 1'b0,
               per: '{100, 80, 100, 0, 0, 0, 0, 0, 0, 0}, n: 0};
    tbl[2] = '{target: 0,  dir: 1, count: 0,  done_off: 1,   npulse: 0,  aborted: 1'b0,
               per: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, n: 0};
    // Abort on cycle 3 of the second pulse: pulse completes, step 2 counted.
    tbl[3] = '{target: 10, dir: 0, count: 2,  done_off: 116, npulse: 2,  aborted: 1'b1,
               per: '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0}, n: 0};
    // Abort in the low phase of window 5: its pulse was emitted but not counted.
    tbl[4] = '{target: 10, dir: 1, count: 4,  done_off: 301, npulse: 5,  aborted: 1'b1,
               per: '{100, 80, 60, 40, 0, 0, 0, 0, 0, 0}, n: 0};
    tbl[5] = '{target: 10, dir: 0, count: 0,  done_off: 3,   npulse: 0,  aborted: 1'b1,
               per: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, n: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0; target = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      launch(i, n);
      wait_done(2000);
    end

    launch(3, n);
    wait_label(n + 108);
    abort = 1'b1;
    wait_done(500);
    abort = 1'b0;

    launch(4, n);
    wait_label(n + 300);
    abort = 1'b1;
    wait_done(500);
    abort = 1'b0;

    launch(5, n);
    wait_label(n + 2);
    abort = 1'b1;
    wait_done(100);
    abort = 1'b0;

    // Reset while a STEP pulse is high.
    launch(0, n);
    wait_label(n + 7);
    chk("step_before_rst", int'(o_step_out), 1);
    sb_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk_reset_state("mid_rst");
    rises.delete();
    falls.delete();
    busy_err = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    launch(0, n);
    wait_done(2000);

    // Start, target and dir_in changes during a move must be ignored.
    launch(0, n);
    wait_label(n + 50);
    start = 1'b1; dir_in = 1'b0; target = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    wait_label(n + 300);
    start = 1'b1; dir_in = 1'b1; target = CNT_W'(0);
    @(negedge clk);
    start = 1'b0; dir_in = 1'b0;
    wait_done(2000);

    // start with abort held in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dir_in = 1'b0; target = CNT_W'(5);
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("busy_start_abort", int'(o_busy), 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("dir_hold_idle",   int'(o_dir_out), 1);
    chk("count_hold_idle", int'(o_step_count), 10);
    repeat (5) @(negedge clk);
    chk("stray_pulses", rises.size(), 0);
    chk("pending_moves", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
